// File: rtl/data_stack_16b_pkg.sv
// Shared constants and operation decode for the 16-bit data stack and its consumers.
// Widths here size the stack datapath, its bus interface and the storage array.
package data_stack_16b_pkg;

  localparam int DS_WIDTH = 16;
  localparam int DS_DEPTH = 16;
  localparam int DS_PTR_W = $clog2(DS_DEPTH);
  localparam int DS_CNT_W = DS_PTR_W + 1;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } stack_op_e;

  // push together with pop means "replace the top entry".
  function automatic stack_op_e decode_op(input logic push, input logic pop);
    case ({push, pop})
      2'b10:   return OP_PUSH;
      2'b01:   return OP_POP;
      2'b11:   return OP_REPLACE;
      default: return OP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/data_stack_16b_if.sv
// Command/status bundle between the data stack and its user (ALU, operand muxes).
// The master modport drives commands; the slave modport is the stack itself.
interface data_stack_16b_if
  import data_stack_16b_pkg::*;
#(
  parameter int WIDTH = DS_WIDTH,
  parameter int DEPTH = DS_DEPTH
);

  logic                       push;
  logic                       pop;
  logic                       clear_err;
  logic [WIDTH-1:0]           D;
  logic [WIDTH-1:0]           TOS;
  logic [WIDTH-1:0]           NOS;
  logic [$clog2(DEPTH):0]     count;
  logic                       empty;
  logic                       full;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output push, pop, clear_err, D,
    input  TOS, NOS, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, clear_err, D,
    output TOS, NOS, count, empty, full, overflow, underflow
  );

endinterface

// File: rtl/stack_ram_16b.sv
// Stack storage: DEPTH x WIDTH registers, one synchronous write port and two
// asynchronous read ports addressed by the top and next-on-stack pointers.
module stack_ram_16b
  import data_stack_16b_pkg::*;
#(
  parameter int WIDTH = DS_WIDTH,
  parameter int DEPTH = DS_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; entries above count are never observed, so
  // clearing them would only add reset fan-out to every bit.
  always_ff @(posedge clk) begin
    if (we) begin
      // NOTE: sequential state is always assigned with <= so every register
      // samples the pre-edge values regardless of statement order.
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/data_stack_16b.sv
// LIFO operand stack: pointer/count and sticky error flags around stack_ram_16b.
// TOS/NOS are combinational views of registered state (one-cycle latency).
module data_stack_16b
  import data_stack_16b_pkg::*;
#(
  parameter int WIDTH = DS_WIDTH,
  parameter int DEPTH = DS_DEPTH
) (
  input  logic               CLK,
  input  logic               Reset_n,
  data_stack_16b_if.slave    bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("data_stack_16b: DEPTH must be a power of two and at least 2");
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_q;
  logic             unf_q;
  logic             set_ovf;
  logic             set_unf;
  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;
  logic [PTR_W-1:0] tos_addr;
  logic [PTR_W-1:0] nos_addr;
  logic [WIDTH-1:0] tos_raw;
  logic [WIDTH-1:0] nos_raw;
  logic             is_empty;
  logic             is_full;
  stack_op_e        op;

  assign is_empty = (cnt_q == '0);
  assign is_full  = (cnt_q == CNT_W'(DEPTH));
  assign tos_addr = PTR_W'(cnt_q - CNT_W'(1));
  assign nos_addr = PTR_W'(cnt_q - CNT_W'(2));

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    op      = decode_op(bus.push, bus.pop);
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = cnt_q[PTR_W-1:0];
    set_ovf = 1'b0;
    set_unf = 1'b0;

    unique case (op)
      OP_PUSH: begin
        if (is_full) begin
          set_ovf = 1'b1;
        end else begin
          wr_en = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OP_POP: begin
        if (is_empty) set_unf = 1'b1;
        else          cnt_d   = cnt_q - CNT_W'(1);
      end
      OP_REPLACE: begin
        // Overwrite the top in place; legal even when full.
        if (is_empty) begin
          set_unf = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_addr = tos_addr;
        end
      end
      default: ;
    endcase

    // Reset outranks a coincident push, so the array is left untouched too.
    if (!Reset_n) wr_en = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      // A new error in the clearing cycle keeps the flag set.
      ovf_q <= set_ovf | (ovf_q & ~bus.clear_err);
      unf_q <= set_unf | (unf_q & ~bus.clear_err);
    end
  end

  stack_ram_16b #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk     (CLK),
    .we      (wr_en),
    .waddr   (wr_addr),
    .wdata   (bus.D),
    .raddr_a (tos_addr),
    .rdata_a (tos_raw),
    .raddr_b (nos_addr),
    .rdata_b (nos_raw)
  );

  assign bus.TOS       = is_empty ? '0 : tos_raw;
  assign bus.NOS       = (cnt_q >= CNT_W'(2)) ? nos_raw : '0;
  assign bus.count     = cnt_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_data_stack_16b.sv
// Directed bench for data_stack_16b: a reference model queues the expected state for
// every cycle and a monitor compares it; hand-computed spot checks cover key points.
module tb_data_stack_16b;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [15:0] tos;
    logic [15:0] nos;
    logic [4:0]  cnt;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];

  // Reference model state.
  logic [15:0] m_mem [DEPTH];
  int          m_cnt;
  logic        m_ovf;
  logic        m_unf;

  data_stack_16b_if bus ();

  data_stack_16b dut (
    .CLK     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_view();
    exp_t e;
    e.tos   = (m_cnt >= 1) ? m_mem[m_cnt-1] : 16'h0;
    e.nos   = (m_cnt >= 2) ? m_mem[m_cnt-2] : 16'h0;
    e.cnt   = 5'(m_cnt);
    e.empty = (m_cnt == 0);
    e.full  = (m_cnt == DEPTH);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  // Drive one cycle of stimulus and queue the state expected after the next edge.
  task automatic step(input logic p, input logic po, input logic c,
                      input logic [15:0] d, input logic r);
    bit so;
    bit su;
    @(negedge clk);
    bus.push      = p;
    bus.pop       = po;
    bus.clear_err = c;
    bus.D         = d;
    rst_n         = r;
    so = 1'b0;
    su = 1'b0;
    if (!r) begin
      m_cnt = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (p && !po) begin
        if (m_cnt == DEPTH) so = 1'b1;
        else begin m_mem[m_cnt] = d; m_cnt++; end
      end else if (!p && po) begin
        if (m_cnt == 0) su = 1'b1;
        else m_cnt--;
      end else if (p && po) begin
        if (m_cnt == 0) su = 1'b1;
        else m_mem[m_cnt-1] = d;
      end
      m_ovf = so | (m_ovf & !c);
      m_unf = su | (m_unf & !c);
    end
    exp_q.push_back(model_view());
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: the DUT presents a full state every cycle; compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tos",       32'(bus.TOS),       32'(e.tos));
        check("nos",       32'(bus.NOS),       32'(e.nos));
        check("count",     32'(bus.count),     32'(e.cnt));
        check("empty",     32'(bus.empty),     32'(e.empty));
        check("full",      32'(bus.full),      32'(e.full));
        check("overflow",  32'(bus.overflow),  32'(e.ovf));
        check("underflow", 32'(bus.underflow), 32'(e.unf));
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    rst_n = 1'b0;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.clear_err = 1'b0;
    bus.D = 16'h0;

    // Reset state.
    step(0, 0, 0, 16'h0, 0);
    step(0, 0, 0, 16'h0, 0);
    settle();
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_tos",   32'(bus.TOS),   0);

    // Basic push/pop.
    step(1, 0, 0, 16'h1111, 1);
    step(1, 0, 0, 16'h2222, 1);
    step(1, 0, 0, 16'h3333, 1);
    settle();
    check("b_tos",   32'(bus.TOS),   32'h3333);
    check("b_nos",   32'(bus.NOS),   32'h2222);
    check("b_count", 32'(bus.count), 3);
    check("b_empty", 32'(bus.empty), 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0, 1);
    settle();
    check("b_pop_tos",   32'(bus.TOS),       0);
    check("b_pop_count", 32'(bus.count),     0);
    check("b_pop_empty", 32'(bus.empty),     1);
    check("b_pop_unf",   32'(bus.underflow), 0);

    // Fill to full, then overflow.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 16'(i), 1);
    settle();
    check("f_full", 32'(bus.full), 1);
    check("f_tos",  32'(bus.TOS),  32'h000F);
    step(1, 0, 0, 16'hBEEF, 1);
    settle();
    check("o_tos",   32'(bus.TOS),      32'h000F);
    check("o_count", 32'(bus.count),    16);
    check("o_ovf",   32'(bus.overflow), 1);
    step(0, 0, 1, 16'h0, 1);
    settle();
    check("o_clr", 32'(bus.overflow), 0);

    // Replace at full: no overflow.
    step(1, 1, 0, 16'h1234, 1);
    settle();
    check("rf_tos",   32'(bus.TOS),      32'h1234);
    check("rf_nos",   32'(bus.NOS),      32'h000E);
    check("rf_count", 32'(bus.count),    16);
    check("rf_ovf",   32'(bus.overflow), 0);

    // Overflow set wins over a coincident clear.
    step(1, 0, 1, 16'h5555, 1);
    settle();
    check("o_setwins", 32'(bus.overflow), 1);
    step(0, 0, 1, 16'h0, 1);

    // Drain, then underflow cases.
    for (int i = 0; i < 16; i++) step(0, 1, 0, 16'h0, 1);
    step(0, 1, 0, 16'h0, 1);
    settle();
    check("u_unf",   32'(bus.underflow), 1);
    check("u_count", 32'(bus.count),     0);
    step(1, 1, 0, 16'h00AA, 1);
    settle();
    check("u_rep_count", 32'(bus.count),     0);
    check("u_rep_unf",   32'(bus.underflow), 1);
    check("u_rep_tos",   32'(bus.TOS),       0);
    step(0, 1, 1, 16'h0, 1);
    settle();
    check("u_setwins", 32'(bus.underflow), 1);
    step(0, 0, 1, 16'h0, 1);
    settle();
    check("u_clr", 32'(bus.underflow), 0);

    // Replace with two entries.
    step(1, 0, 0, 16'h0005, 1);
    step(1, 0, 0, 16'h0007, 1);
    step(1, 1, 0, 16'h0009, 1);
    settle();
    check("r_tos",   32'(bus.TOS),   32'h0009);
    check("r_nos",   32'(bus.NOS),   32'h0005);
    check("r_count", 32'(bus.count), 2);

    // Reset mid-sequence with a coincident push; leave an underflow pending first.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 16'hA000 + 16'(i), 1);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 16'h0, 1);
    step(1, 0, 0, 16'hC0DE, 1);
    step(1, 0, 0, 16'hFFFF, 0);
    settle();
    check("mr_count", 32'(bus.count),     0);
    check("mr_tos",   32'(bus.TOS),       0);
    check("mr_nos",   32'(bus.NOS),       0);
    check("mr_unf",   32'(bus.underflow), 0);
    check("mr_ovf",   32'(bus.overflow),  0);
    step(1, 0, 0, 16'h0042, 1);
    settle();
    check("mr_push_tos",   32'(bus.TOS),   32'h0042);
    check("mr_push_count", 32'(bus.count), 1);
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);

    // Let the monitor consume every queued expectation, bounded.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    check("drain", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
